// File: rtl/spi_ram_responder.sv
// spi_ram_responder: CPU bus responder backed by a 23LC-style SPI SRAM.
// Each bus access becomes one 32-bit mode-0 frame: cmd, addr16, data8.
module spi_ram_responder #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_address,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic        bus_wait,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [31:0]    tx_shift;
    logic [7:0]     rx_shift;
    logic [4:0]     bit_cnt;
    logic [DW-1:0]  div_cnt;
    logic           is_rd;
    logic           req;
    logic           tick;
    logic           last;
    logic [31:0]    frame;

    assign req   = bus_read | bus_write;
    assign tick  = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign last  = tick && spi_sck && (bit_cnt == 5'd31);
    // A simultaneous read and write request is treated as a read.
    assign frame = {bus_read ? 8'h03 : 8'h02,
                    bus_address,
                    bus_read ? 8'h00 : bus_wdata};

    // Next state and bus_wait; bus_wait must rise in the request cycle.
    always_comb begin
        state_d  = state;
        bus_wait = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_d  = SHIFT;
                    bus_wait = 1'b1;
                end
            end
            SHIFT: begin
                bus_wait = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (!req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) bus_wait = 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // SPI datapath: frame load, SCK divider, bit shifting, read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_cs_n  <= 1'b1;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            bus_rdata <= 8'h00;
            tx_shift  <= 32'h0;
            rx_shift  <= 8'h00;
            bit_cnt   <= 5'd0;
            div_cnt   <= '0;
            is_rd     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        tx_shift <= {frame[30:0], 1'b0};
                        spi_mosi <= frame[31];
                        spi_cs_n <= 1'b0;
                        spi_sck  <= 1'b0;
                        bit_cnt  <= 5'd0;
                        div_cnt  <= '0;
                        is_rd    <= bus_read;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        div_cnt <= '0;
                        spi_sck <= ~spi_sck;
                        if (!spi_sck) begin
                            rx_shift <= {rx_shift[6:0], spi_miso};
                        end else if (bit_cnt != 5'd31) begin
                            spi_mosi <= tx_shift[31];
                            tx_shift <= {tx_shift[30:0], 1'b0};
                            bit_cnt  <= bit_cnt + 5'd1;
                        end else begin
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                            if (is_rd) bus_rdata <= rx_shift;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// tb_spi_ram_responder: bus-level tests against a behavioural SPI SRAM.
// Two DUT instances cover CLK_DIV=1 and CLK_DIV=3; sel picks the active one.
module tb_spi_ram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [15:0] bus_address = 16'h0;
    logic [7:0]  bus_wdata = 8'h0;
    logic        bus_read = 1'b0;
    logic        bus_write = 1'b0;
    logic        miso = 1'b0;

    logic [7:0] rdata1, rdata3;
    logic       wait1, wait3, cs1, cs3, sck1, sck3, mosi1, mosi3;

    logic       rd1, wr1, rd3, wr3;
    assign rd1 = bus_read & ~sel;
    assign wr1 = bus_write & ~sel;
    assign rd3 = bus_read & sel;
    assign wr3 = bus_write & sel;

    logic [7:0] bus_rdata;
    logic       bus_wait, cs_n, sck, mosi;
    assign bus_rdata = sel ? rdata3 : rdata1;
    assign bus_wait  = sel ? wait3 : wait1;
    assign cs_n      = sel ? cs3 : cs1;
    assign sck       = sel ? sck3 : sck1;
    assign mosi      = sel ? mosi3 : mosi1;

    spi_ram_responder #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst),
        .bus_address(bus_address), .bus_wdata(bus_wdata),
        .bus_rdata(rdata1), .bus_read(rd1), .bus_write(wr1),
        .bus_wait(wait1), .spi_cs_n(cs1), .spi_sck(sck1),
        .spi_mosi(mosi1), .spi_miso(miso)
    );

    spi_ram_responder #(.CLK_DIV(3)) dut3 (
        .clk(clk), .rst(rst),
        .bus_address(bus_address), .bus_wdata(bus_wdata),
        .bus_rdata(rdata3), .bus_read(rd3), .bus_write(wr3),
        .bus_wait(wait3), .spi_cs_n(cs3), .spi_sck(sck3),
        .spi_mosi(mosi3), .spi_miso(miso)
    );

    // ---------------- SPI SRAM model ----------------
    logic [7:0]  seed   [0:65535];
    logic [7:0]  wr_mem [0:65535];
    bit          wr_valid [0:65535];
    logic [7:0]  exp_mem [0:65535];
    logic [31:0] frames [$];
    int          aborted = 0;
    int          nbits = 0;
    logic [31:0] sh = 32'h0;
    logic [7:0]  rd_byte = 8'h0;
    bit          rd_frame = 0;
    logic        p_cs = 1'b1;
    logic        p_sck = 1'b0;

    function automatic logic [7:0] sram_rd(input logic [15:0] a);
        return wr_valid[a] ? wr_mem[a] : seed[a];
    endfunction

    always @(cs_n, sck) begin
        if (!$isunknown({cs_n, sck})) begin
            if (cs_n !== p_cs) begin
                if (!cs_n) begin
                    nbits = 0;
                    sh = 32'h0;
                    rd_frame = 0;
                    miso = 1'b0;
                end else begin
                    if (nbits == 32) begin
                        frames.push_back(sh);
                        if (sh[31:24] == 8'h02) begin
                            wr_mem[sh[23:8]] = sh[7:0];
                            wr_valid[sh[23:8]] = 1'b1;
                        end
                    end else begin
                        aborted++;
                    end
                    miso = 1'b0;
                end
            end else if (!cs_n && sck !== p_sck) begin
                if (sck) begin
                    sh = {sh[30:0], mosi};
                    nbits++;
                    if (nbits == 24) begin
                        rd_frame = (sh[23:16] == 8'h03);
                        rd_byte = sram_rd(sh[15:0]);
                    end
                end else if (rd_frame && nbits >= 24 && nbits < 32) begin
                    miso = rd_byte[31 - nbits];
                end
            end
            p_cs = cs_n;
            p_sck = sck;
        end
    end

    // ---------------- frame timing monitor ----------------
    int   cyc = 0, cs_low = 0, rises = 0, last_rise = -1;
    int   pmin = 0, pmax = 0, hi_cnt = 100;
    int   m_cs_low = 0, m_rises = 0, m_pmin = 0, m_pmax = 0, m_gap = 0;
    logic pm_cs = 1'b1, pm_sck = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!$isunknown({cs_n, sck})) begin
            if (!cs_n && pm_cs) begin
                m_gap = hi_cnt;
                cs_low = 0;
                rises = 0;
                pmin = 1000000;
                pmax = 0;
                last_rise = -1;
            end
            if (cs_n && !pm_cs) begin
                m_cs_low = cs_low;
                m_rises = rises;
                m_pmin = pmin;
                m_pmax = pmax;
                hi_cnt = 0;
            end
            if (!cs_n) cs_low++;
            else       hi_cnt++;
            if (!cs_n && sck && !pm_sck) begin
                rises++;
                if (last_rise >= 0) begin
                    if (cyc - last_rise < pmin) pmin = cyc - last_rise;
                    if (cyc - last_rise > pmax) pmax = cyc - last_rise;
                end
                last_rise = cyc;
            end
            pm_cs = cs_n;
            pm_sck = sck;
        end
    end

    // ---------------- bench bookkeeping ----------------
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_rd = 8'h00;

    function automatic logic [31:0] newest(input int n0);
        if (frames.size() > n0) return frames[$];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic access(input logic rd, input logic wr,
                          input logic [15:0] a, input logic [7:0] d,
                          input bit scramble,
                          output int wc, output logic [7:0] rv);
        @(negedge clk);
        bus_read = rd;
        bus_write = wr;
        bus_address = a;
        bus_wdata = d;
        wc = 0;
        #1;
        while (bus_wait === 1'b1 && wc < 5000) begin
            wc++;
            @(negedge clk);
            if (scramble) begin
                bus_address = 16'($urandom);
                bus_wdata = 8'($urandom);
            end
            #1;
        end
        rv = bus_rdata;
    endtask

    task automatic release_bus();
        @(negedge clk);
        bus_read = 1'b0;
        bus_write = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus_read = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus_wait !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait: got %b want 0", bus_wait);
        end
        checks++;
        if (cs_n !== 1'b1) begin
            failures++;
            $display("FAIL rst_cs: got %b want 1", cs_n);
        end
        checks++;
        if (sck !== 1'b0) begin
            failures++;
            $display("FAIL rst_sck: got %b want 0", sck);
        end
        checks++;
        if (mosi !== 1'b0) begin
            failures++;
            $display("FAIL rst_mosi: got %b want 0", mosi);
        end
        checks++;
        if (bus_rdata !== 8'h00) begin
            failures++;
            $display("FAIL rst_rdata: got %h want 00", bus_rdata);
        end
        bus_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_rd = 8'h00;
    endtask

    task automatic test_write_basic();
        int n0, wc;
        logic [7:0] rv;
        logic [31:0] f;
        n0 = frames.size();
        access(1'b0, 1'b1, 16'h1234, 8'hA5, 1'b0, wc, rv);
        exp_mem[16'h1234] = 8'hA5;
        f = newest(n0);
        checks++;
        if (wc !== 65) begin
            failures++;
            $display("FAIL wr_wait: got %0d want 65", wc);
        end
        checks++;
        if (f !== 32'h021234A5) begin
            failures++;
            $display("FAIL wr_frame: got %h want 021234a5", f);
        end
        checks++;
        if (m_cs_low !== 64) begin
            failures++;
            $display("FAIL wr_cs_low: got %0d want 64", m_cs_low);
        end
        checks++;
        if (rv !== exp_rd) begin
            failures++;
            $display("FAIL wr_rdata: got %h want %h", rv, exp_rd);
        end
        release_bus();
    endtask

    task automatic test_read_basic();
        int n0, wc;
        logic [7:0] rv;
        logic [31:0] f;
        seed[16'hBEEF] = 8'h3C;
        exp_mem[16'hBEEF] = 8'h3C;
        n0 = frames.size();
        access(1'b1, 1'b0, 16'hBEEF, 8'h77, 1'b0, wc, rv);
        f = newest(n0);
        checks++;
        if (wc !== 65) begin
            failures++;
            $display("FAIL rd_wait: got %0d want 65", wc);
        end
        checks++;
        if (f !== 32'h03BEEF00) begin
            failures++;
            $display("FAIL rd_frame: got %h want 03beef00", f);
        end
        checks++;
        if (rv !== 8'h3C) begin
            failures++;
            $display("FAIL rd_data: got %h want 3c", rv);
        end
        exp_rd = 8'h3C;
        release_bus();
    endtask

    task automatic test_clkdiv3();
        int n0, wc;
        logic [7:0] rv;
        logic [31:0] f;
        @(negedge clk);
        sel = 1'b1;
        n0 = frames.size();
        access(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, wc, rv);
        f = newest(n0);
        checks++;
        if (wc !== 193) begin
            failures++;
            $display("FAIL d3_wait: got %0d want 193", wc);
        end
        checks++;
        if (m_rises !== 32) begin
            failures++;
            $display("FAIL d3_rises: got %0d want 32", m_rises);
        end
        checks++;
        if (m_pmin !== 6 || m_pmax !== 6) begin
            failures++;
            $display("FAIL d3_period: got %0d..%0d want 6", m_pmin, m_pmax);
        end
        checks++;
        if (m_cs_low !== 192) begin
            failures++;
            $display("FAIL d3_cs_low: got %0d want 192", m_cs_low);
        end
        checks++;
        if (f !== 32'h03000000) begin
            failures++;
            $display("FAIL d3_frame: got %h want 03000000", f);
        end
        checks++;
        if (rv !== exp_mem[0]) begin
            failures++;
            $display("FAIL d3_data: got %h want %h", rv, exp_mem[0]);
        end
        release_bus();
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n0, ab0, k, wc;
        logic [15:0] a;
        logic [7:0] d, rv;
        logic [31:0] f;
        n0 = frames.size();
        ab0 = aborted;
        a = 16'h0400 + 16'($urandom_range(0, 255));
        d = ~exp_mem[a];
        @(negedge clk);
        bus_write = 1'b1;
        bus_address = a;
        bus_wdata = d;
        k = 0;
        while ((cs_n !== 1'b0 || nbits < 10) && k < 500) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 500) begin
            failures++;
            $display("FAIL mid_reach_bit10: got timeout want bit 10");
        end
        rst = 1'b1;
        bus_write = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (cs_n !== 1'b1 || sck !== 1'b0 || bus_wait !== 1'b0) begin
            failures++;
            $display("FAIL mid_abort: got cs=%b sck=%b wait=%b want 1 0 0",
                     cs_n, sck, bus_wait);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_rd = 8'h00;
        checks++;
        if (aborted !== ab0 + 1 || frames.size() !== n0) begin
            failures++;
            $display("FAIL mid_frames: got aborted=%0d done=%0d want %0d %0d",
                     aborted - ab0, frames.size() - n0, 1, 0);
        end
        checks++;
        if (sram_rd(a) !== exp_mem[a]) begin
            failures++;
            $display("FAIL mid_nowrite: got %h want %h", sram_rd(a), exp_mem[a]);
        end
        n0 = frames.size();
        access(1'b1, 1'b0, 16'h0001, 8'h00, 1'b0, wc, rv);
        f = newest(n0);
        checks++;
        if (wc !== 65 || f !== 32'h03000100) begin
            failures++;
            $display("FAIL mid_next_read: got wait=%0d frame=%h want 65 03000100",
                     wc, f);
        end
        checks++;
        if (rv !== exp_mem[1]) begin
            failures++;
            $display("FAIL mid_next_data: got %h want %h", rv, exp_mem[1]);
        end
        exp_rd = exp_mem[1];
        release_bus();
    endtask

    task automatic test_back_to_back();
        int n0, wc;
        logic [15:0] a, b;
        logic [7:0] d, rv;
        logic [31:0] f;
        a = 16'h3000 + 16'($urandom_range(0, 255));
        d = 8'($urandom);
        access(1'b0, 1'b1, a, d, 1'b0, wc, rv);
        exp_mem[a] = d;
        checks++;
        if (wc !== 65 || rv !== exp_rd) begin
            failures++;
            $display("FAIL b2b_write: got wait=%0d rdata=%h want 65 %h",
                     wc, rv, exp_rd);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus_wait !== 1'b0 || bus_rdata !== exp_rd) begin
                failures++;
                $display("FAIL b2b_hold%0d: got wait=%b rdata=%h want 0 %h",
                         i, bus_wait, bus_rdata, exp_rd);
            end
        end
        release_bus();
        b = a;
        n0 = frames.size();
        access(1'b1, 1'b0, b, 8'h00, 1'b0, wc, rv);
        f = newest(n0);
        checks++;
        if (m_gap < 2) begin
            failures++;
            $display("FAIL b2b_gap: got %0d want >=2", m_gap);
        end
        checks++;
        if (wc !== 65 || f !== {8'h03, b, 8'h00}) begin
            failures++;
            $display("FAIL b2b_read: got wait=%0d frame=%h want 65 %h",
                     wc, f, {8'h03, b, 8'h00});
        end
        checks++;
        if (rv !== exp_mem[b]) begin
            failures++;
            $display("FAIL b2b_data: got %h want %h", rv, exp_mem[b]);
        end
        exp_rd = exp_mem[b];
        release_bus();
    endtask

    task automatic test_both_req();
        int n0, wc;
        logic [7:0] rv;
        logic [31:0] f;
        n0 = frames.size();
        access(1'b1, 1'b1, 16'h00FF, 8'($urandom), 1'b1, wc, rv);
        f = newest(n0);
        checks++;
        if (f !== 32'h0300FF00) begin
            failures++;
            $display("FAIL both_frame: got %h want 0300ff00", f);
        end
        checks++;
        if (wc !== 65 || rv !== exp_mem[16'h00FF]) begin
            failures++;
            $display("FAIL both_data: got wait=%0d rdata=%h want 65 %h",
                     wc, rv, exp_mem[16'h00FF]);
        end
        exp_rd = exp_mem[16'h00FF];
        release_bus();
    endtask

    task automatic test_random();
        int n0, wc;
        bit rd;
        logic [15:0] a;
        logic [7:0] d, rv, want;
        logic [31:0] f, fw;
        for (int i = 0; i < 16; i++) begin
            rd = 1'($urandom_range(0, 1));
            a = 16'h2000 + 16'($urandom_range(0, 7));
            d = 8'($urandom);
            n0 = frames.size();
            access(rd, ~rd, a, d, 1'b0, wc, rv);
            f = newest(n0);
            fw = rd ? {8'h03, a, 8'h00} : {8'h02, a, d};
            want = rd ? exp_mem[a] : exp_rd;
            checks++;
            if (wc !== 65 || f !== fw) begin
                failures++;
                $display("FAIL rnd%0d_frame: got wait=%0d frame=%h want 65 %h",
                         i, wc, f, fw);
            end
            checks++;
            if (rv !== want) begin
                failures++;
                $display("FAIL rnd%0d_rdata: got %h want %h", i, rv, want);
            end
            if (rd) exp_rd = exp_mem[a];
            else    exp_mem[a] = d;
            release_bus();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            seed[i] = 8'($urandom);
            exp_mem[i] = seed[i];
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_clkdiv3();
        test_reset_mid();
        test_back_to_back();
        test_both_req();
        test_random();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
